// File: rtl/mdr_pkg.sv
// mdr_pkg: shared definitions for the memory data register controller.
//   state_t      - controller FSM states
//   DATA_W_DEF   - default data register / bus width
//   TIMEOUT_DEF  - default number of wait cycles before a DRAM access is abandoned
//   cnt_width()  - bits needed by the wait counter to hold 0..timeout
package mdr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 15;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mdr_timeout_cnt.sv
// mdr_timeout_cnt: wait-cycle counter for a pending DRAM access.
//   i_clk, i_rst  - clock, asynchronous active-high reset
//   i_clear       - hold the count at zero (asserted while no access is pending)
//   i_enable      - count this cycle (waiting, no ack)
//   o_expired     - this edge is the one on which the count reaches TIMEOUT
module mdr_timeout_cnt
  import mdr_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Count TIMEOUT-1 plus one more unacknowledged wait cycle means the
  // TIMEOUT-th wait cycle is ending without an ack.
  assign o_expired = i_enable && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mdr_ctrl.sv
// mdr_ctrl: memory data register with a DRAM read/write handshake controller.
//   clk, rst        - clock, asynchronous active-high reset
//   load, C_bus     - load the register from the datapath
//   read, write     - start a DRAM read into / write from the register
//   data_in_DRAM    - DRAM read data, sampled on the mem_ack edge
//   mem_ack         - DRAM access-complete strobe
//   data_out_Bbus   - register contents to the B bus
//   data_out_DRAM   - register contents to DRAM
//   mem_req, mem_we - DRAM request and direction (1 = write)
//   busy, done, err - access in progress, completion pulse, sticky timeout flag
module mdr_ctrl
  import mdr_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] C_bus,
  input  logic [DATA_W-1:0] data_in_DRAM,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] data_out_Bbus,
  output logic [DATA_W-1:0] data_out_DRAM,
  output logic              mem_req,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_data;
  logic              r_done;
  logic              r_err;

  logic w_in_wait;
  logic w_expired;
  logic w_cmd_acc;
  logic w_load_acc;
  logic w_rd_ack;
  logic w_done_nxt;
  logic w_timeout;

  assign w_in_wait = (r_state != IDLE);

  // Counter sits at zero whenever idle, so every wait state starts from zero.
  mdr_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clear   (!w_in_wait),
    .i_enable  (w_in_wait && !mem_ack),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cmd_acc  = 1'b0;
    w_load_acc = 1'b0;
    w_rd_ack   = 1'b0;
    w_done_nxt = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      IDLE: begin
        // read > write > load; losers are simply dropped.
        if (read) begin
          w_next    = RD_WAIT;
          w_cmd_acc = 1'b1;
        end else if (write) begin
          w_next    = WR_WAIT;
          w_cmd_acc = 1'b1;
        end else if (load) begin
          w_cmd_acc  = 1'b1;
          w_load_acc = 1'b1;
          w_done_nxt = 1'b1;
        end
      end
      RD_WAIT: begin
        // An ack on the expiry edge still counts as a normal completion.
        if (mem_ack) begin
          w_next     = IDLE;
          w_rd_ack   = 1'b1;
          w_done_nxt = 1'b1;
        end else if (w_expired) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
      end
      WR_WAIT: begin
        if (mem_ack) begin
          w_next     = IDLE;
          w_done_nxt = 1'b1;
        end else if (w_expired) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_load_acc) begin
        r_data <= C_bus;
      end else if (w_rd_ack) begin
        r_data <= data_in_DRAM;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (w_cmd_acc) begin
        r_err <= 1'b0;
      end
    end
  end

  assign data_out_Bbus = r_data;
  assign data_out_DRAM = r_data;
  assign mem_req       = w_in_wait;
  assign mem_we        = (r_state == WR_WAIT);
  assign busy          = w_in_wait;
  assign done          = r_done;
  assign err           = r_err;

endmodule
